dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning the number of 32-bit words stored (power of two, 16..4096).
REQ-002 SHALL have parameter LATENCY, default 3, meaning the cycles from request acceptance to the response cycle (legal range 1..15).
REQ-003 SHALL have a single clock and an asynchronous, active-low reset; reset is asserted when low.
REQ-004 clock  in  1  system clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  asynchronous active-low reset.
REQ-006 MemRead  in  1  load request from the MEM stage.
REQ-007 MemWrite  in  1  store request from the MEM stage.
REQ-008 addr  in  32  byte address (ALU result).
REQ-009 wdata  in  32  store data.
REQ-010 rdata  out  32  load data; valid only when done=1.
REQ-011 mem_busy  out  1  pipeline stall; while high, the PC, IF/ID, ID/EX and EX/MEM registers hold.
REQ-012 done  out  1  single-cycle completion pulse.
REQ-013 mem_err  out  1  error flag; valid only with done=1.

Function
REQ-014 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-015 IDLE, when MemRead|MemWrite=1: SHALL latch the request type, addr and wdata; SHALL set cnt=LATENCY-1; next state is WAIT if LATENCY>1, otherwise RESP.
REQ-016 IDLE with no request SHALL remain in IDLE.
REQ-017 WAIT SHALL decrement cnt each cycle and go to RESP in the cycle after cnt reaches 1; total request-to-RESP time is exactly LATENCY cycles.
REQ-018 RESP SHALL last exactly one cycle, then go to IDLE.
REQ-019 RESP SHALL ignore MemRead/MemWrite; the same instruction is still presented during RESP.
REQ-020 mem_busy SHALL equal (IDLE & (MemRead|MemWrite)) | WAIT; this is combinational so the pipeline freezes in the request cycle. mem_busy SHALL be 0 in RESP.
REQ-021 done SHALL be 1 only in RESP.
REQ-022 rdata SHALL be registered. In RESP for a legal load it SHALL equal mem[index]; at all other times it SHALL be 0.
REQ-023 A legal store SHALL write mem[index] <= wdata on the clock edge that ends RESP. A load issued in the next request SHALL observe the new value.
REQ-024 index SHALL be addr[2 +: log2(DEPTH_WORDS)]; upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
REQ-025 addr[1:0]!=0 SHALL be an error: no memory access, rdata=0, mem_err=1 in RESP, and normal latency.
REQ-026 MemRead=MemWrite=1 SHALL be an error: no access, mem_err=1 in RESP, and normal latency.
REQ-027 Back-to-back requests SHALL have exactly one IDLE cycle between consecutive RESP cycles (the next instruction's request cycle); there is no pipelining of requests.

Reset
REQ-028 reset_n low SHALL force the state to IDLE, cnt=0, latched fields to 0, rdata=0, done=0 and mem_err=0.
REQ-029 mem_busy SHALL go to 0 when reset_n is low, independent of the request inputs.
REQ-030 Reset mid-WAIT SHALL discard the pending request; a pending store SHALL NOT be written.
REQ-031 Memory array contents SHALL NOT be reset.

Structure
REQ-032 The shared constants header SHALL hold the FSM state encodings (IDLE=2'b00, WAIT=2'b01, RESP=2'b10) and the default LATENCY and DEPTH_WORDS values.
REQ-033 The storage SHALL be one sub-module, dmem_array: synchronous write, asynchronous read, parameterised by depth. The FSM and counter SHALL live in dmem_responder.

Verification
REQ-034 Reset release, then SW addr=0x10 wdata=0xDEADBEEF (LATENCY=3) -> mem_busy high for cycles 0..2, done at cycle 3, mem_err=0.
REQ-035 LW addr=0x10 after REQ-034 -> rdata=0xDEADBEEF together with done, 3 cycles after the request.
REQ-036 LW addr=0x13 -> done after 3 cycles with mem_err=1 and rdata=0; the memory is unchanged.
REQ-037 MemRead=MemWrite=1 at addr=0x20 -> mem_err=1 with done; the word at 0x20 is unchanged.
REQ-038 SW to 0x400 with DEPTH_WORDS=256, then LW 0x0 -> the loaded value is the stored data (wrap-around).
REQ-039 SW 0x30=0x1234, with reset_n pulsed low during WAIT -> mem_busy drops immediately, no done pulse; a subsequent LW 0x30 returns the old value. Repeat the store/load check with LATENCY=1 -> done occurs 1 cycle after the request and there is no WAIT state.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared constants and types for the data-memory responder: FSM state
// encodings, default geometry/latency, and request-error classification.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WAIT = 2'b01,
        ST_RESP = 2'b10
    } state_t;

    localparam int DEF_LATENCY     = 3;
    localparam int DEF_DEPTH_WORDS = 256;

    // A request is illegal when it asks for both a load and a store, or when
    // the byte address is not word aligned.
    function automatic logic req_is_err(input logic rd, input logic wr,
                                        input logic [1:0] lsb);
        req_is_err = (rd & wr) | (lsb != 2'b00);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage <-> data-memory bus: request fields from the pipeline and the
// completion/stall/data signals returned by the responder.
interface dmem_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        mem_busy;
    logic        done;
    logic        mem_err;

    modport master (
        output MemRead, MemWrite, addr, wdata,
        input  rdata, mem_busy, done, mem_err
    );

    modport slave (
        input  MemRead, MemWrite, addr, wdata,
        output rdata, mem_busy, done, mem_err
    );
endinterface

// File: rtl/dmem_responder_array.sv
// Word-wide storage for the data memory: synchronous write, asynchronous
// read. Contents are deliberately not reset.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clock,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [31:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [31:0]   o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    // Store port: write the addressed word on the rising edge when enabled.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency data-memory responder for an in-order pipeline. A request
// seen in IDLE is latched, the pipeline is stalled through WAIT, and a
// single RESP cycle presents done/rdata/mem_err. Stores commit at the end
// of RESP so a following load observes them.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic            clock,
    input  logic            reset_n,
    dmem_responder_if.slave bus
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_cnt;
    logic [3:0]  w_next_cnt;

    logic        r_is_read;
    logic        r_is_write;
    logic        r_err;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;

    logic [31:0] r_rdata;
    logic        r_done;
    logic        r_mem_err;

    logic        w_req;
    logic        w_accept;
    logic        w_live_err;
    logic        w_eff_read;
    logic        w_eff_err;
    logic [31:0] w_eff_addr;
    logic        w_load_ok;
    logic        w_we;
    logic        w_resp_next;
    logic [31:0] w_rd_word;

    assign w_req      = bus.MemRead | bus.MemWrite;
    assign w_accept   = (r_state == ST_IDLE) & w_req;
    assign w_live_err = req_is_err(bus.MemRead, bus.MemWrite, bus.addr[1:0]);

    // With LATENCY=1 the response is prepared in the request cycle itself,
    // before the latched copy exists, so use the live inputs in IDLE.
    assign w_eff_read = (r_state == ST_IDLE) ? bus.MemRead : r_is_read;
    assign w_eff_err  = (r_state == ST_IDLE) ? w_live_err  : r_err;
    assign w_eff_addr = (r_state == ST_IDLE) ? bus.addr    : r_addr;
    assign w_load_ok  = w_eff_read & ~w_eff_err;

    assign w_resp_next = (w_next_state == ST_RESP);
    assign w_we        = (r_state == ST_RESP) & r_is_write & ~r_err;

    // Stall is combinational so the pipeline freezes in the request cycle;
    // it is forced low while reset is asserted.
    assign bus.mem_busy = reset_n & (w_accept | (r_state == ST_WAIT));
    assign bus.rdata    = r_rdata;
    assign bus.done     = r_done;
    assign bus.mem_err  = r_mem_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clock   (clock),
        .i_we    (w_we),
        .i_waddr (r_addr[2 +: AW]),
        .i_wdata (r_wdata),
        .i_raddr (w_eff_addr[2 +: AW]),
        .o_rdata (w_rd_word)
    );

    // Next-state and latency-counter logic.
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_req) begin
                    w_next_cnt = CNT_INIT;
                    if (LATENCY > 1) begin
                        w_next_state = ST_WAIT;
                    end else begin
                        w_next_state = ST_RESP;
                    end
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (r_cnt <= 4'd1) begin
                    w_next_state = ST_RESP;
                    w_next_cnt   = 4'd0;
                end else begin
                    w_next_cnt   = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = 4'd0;
            end
            default: begin
                w_next_state = ST_IDLE;
                w_next_cnt   = 4'd0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_next_cnt;
        end
    end

    // Capture the request on acceptance; hold it through WAIT and RESP.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_is_read  <= 1'b0;
            r_is_write <= 1'b0;
            r_err      <= 1'b0;
            r_addr     <= 32'h0000_0000;
            r_wdata    <= 32'h0000_0000;
        end else if (w_accept) begin
            r_is_read  <= bus.MemRead;
            r_is_write <= bus.MemWrite;
            r_err      <= w_live_err;
            r_addr     <= bus.addr;
            r_wdata    <= bus.wdata;
        end
    end

    // Registered response outputs, valid only during the RESP cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata   <= 32'h0000_0000;
            r_done    <= 1'b0;
            r_mem_err <= 1'b0;
        end else begin
            r_done    <= w_resp_next;
            r_mem_err <= w_resp_next & w_eff_err;
            r_rdata   <= (w_resp_next & w_load_ok) ? w_rd_word : 32'h0000_0000;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: one instance with LATENCY=3 and one
// with LATENCY=1. Requests push expected responses (data, error flag,
// completion cycle); per-instance monitors pop and compare on every done.
module tb_dmem_responder;

    typedef struct packed {
        logic [31:0] rd;
        logic        err;
        int          cyc;
    } exp_t;

    logic clk;
    logic rst3_n;
    logic rst1_n;
    int   cyc;
    int   n_checks;
    int   n_errors;
    exp_t q3[$];
    exp_t q1[$];

    dmem_responder_if if3 ();
    dmem_responder_if if1 ();

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_dut3 (
        .clock   (clk),
        .reset_n (rst3_n),
        .bus     (if3.slave)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
        .clock   (clk),
        .reset_n (rst1_n),
        .bus     (if1.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive(input bit sel, input logic rd, input logic wr,
                         input logic [31:0] a, input logic [31:0] wd);
        if (sel) begin
            if1.MemRead = rd; if1.MemWrite = wr; if1.addr = a; if1.wdata = wd;
        end else begin
            if3.MemRead = rd; if3.MemWrite = wr; if3.addr = a; if3.wdata = wd;
        end
    endtask

    function automatic logic get_busy(input bit sel);
        return sel ? if1.mem_busy : if3.mem_busy;
    endfunction

    function automatic logic get_done(input bit sel);
        return sel ? if1.done : if3.done;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Pop and compare one response for the selected instance.
    task automatic score(input bit sel, input logic [31:0] rd, input logic err);
        exp_t e;
        n_checks++;
        if ((sel ? q1.size() : q3.size()) == 0) begin
            n_errors++;
            $display("FAIL resp%0d: unexpected done at cycle %0d", sel ? 1 : 3, cyc);
        end else begin
            e = sel ? q1.pop_front() : q3.pop_front();
            if (rd !== e.rd || err !== e.err || cyc != e.cyc) begin
                n_errors++;
                $display("FAIL resp%0d: got rdata=%h err=%b cyc=%0d expected rdata=%h err=%b cyc=%0d",
                         sel ? 1 : 3, rd, err, cyc, e.rd, e.err, e.cyc);
            end
        end
    endtask

    // Monitors: compare whenever a done pulse is presented.
    always @(negedge clk) if (if3.done === 1'b1) score(1'b0, if3.rdata, if3.mem_err);
    always @(negedge clk) if (if1.done === 1'b1) score(1'b1, if1.rdata, if1.mem_err);

    // Issue one request starting at the next clock, check mem_busy every
    // cycle up to and including the done cycle; inputs stay held afterwards.
    task automatic req(input bit sel, input logic rd, input logic wr,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] er, input logic ee, input string nm);
        int   lat;
        int   c0;
        bit   got;
        exp_t e;
        lat = sel ? 1 : 3;
        @(posedge clk);
        #1;
        drive(sel, rd, wr, a, wd);
        c0 = cyc;
        e.rd = er; e.err = ee; e.cyc = c0 + lat;
        if (sel) q1.push_back(e); else q3.push_back(e);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            check({nm, " busy"}, {31'd0, get_busy(sel)}, {31'd0, (cyc - c0) < lat});
            if (get_done(sel) === 1'b1) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout: done=0 expected done=1", nm);
        end
    endtask

    task automatic idle(input bit sel);
        @(posedge clk);
        #1;
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        cyc = 0;
        n_checks = 0;
        n_errors = 0;
        rst3_n = 1'b0;
        rst1_n = 1'b0;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0);
        #12;
        check("rst busy3", {31'd0, if3.mem_busy}, 32'd0);
        check("rst done3", {31'd0, if3.done}, 32'd0);
        check("rst err3", {31'd0, if3.mem_err}, 32'd0);
        check("rst rdata3", if3.rdata, 32'h0);
        check("rst busy1", {31'd0, if1.mem_busy}, 32'd0);
        check("rst rdata1", if1.rdata, 32'h0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rst3_n = 1'b1;
        rst1_n = 1'b1;
        idle(1'b0);

        // LATENCY=3 instance: store/load, misaligned, dual request, wrap.
        req(1'b0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 32'h0, 1'b0, "sw10");
        req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, "lw10");
        req(1'b0, 1'b1, 1'b0, 32'h13, 32'h0, 32'h0, 1'b1, "lw13");
        req(1'b0, 1'b0, 1'b1, 32'h11, 32'h55, 32'h0, 1'b1, "sw11");
        req(1'b0, 1'b1, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF, 1'b0, "lw10b");
        req(1'b0, 1'b0, 1'b1, 32'h20, 32'h1111_2222, 32'h0, 1'b0, "sw20");
        req(1'b0, 1'b1, 1'b1, 32'h20, 32'h99, 32'h0, 1'b1, "rw20");
        req(1'b0, 1'b1, 1'b0, 32'h20, 32'h0, 32'h1111_2222, 1'b0, "lw20");
        req(1'b0, 1'b0, 1'b1, 32'h400, 32'hA5A5_5A5A, 32'h0, 1'b0, "sw400");
        req(1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'hA5A5_5A5A, 1'b0, "lw0");
        req(1'b0, 1'b1, 1'b0, 32'h8000_0400, 32'h0, 32'hA5A5_5A5A, 1'b0, "lwhi");
        idle(1'b0);
        req(1'b0, 1'b0, 1'b1, 32'h30, 32'hCAFE_F00D, 32'h0, 1'b0, "sw30");
        idle(1'b0);

        // Store aborted by reset during WAIT must not commit.
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b1, 32'h30, 32'h1234);
        @(posedge clk);
        #1;
        check("abort busy wait", {31'd0, if3.mem_busy}, 32'd1);
        rst3_n = 1'b0;
        #1;
        check("abort busy rst", {31'd0, if3.mem_busy}, 32'd0);
        check("abort done rst", {31'd0, if3.done}, 32'd0);
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rst3_n = 1'b1;
        repeat (4) @(posedge clk);
        req(1'b0, 1'b1, 1'b0, 32'h30, 32'h0, 32'hCAFE_F00D, 1'b0, "lw30 old");
        idle(1'b0);

        // LATENCY=1 instance.
        req(1'b1, 1'b0, 1'b1, 32'h30, 32'h1234, 32'h0, 1'b0, "l1 sw30");
        req(1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 32'h1234, 1'b0, "l1 lw30");
        req(1'b1, 1'b1, 1'b0, 32'h31, 32'h0, 32'h0, 1'b1, "l1 lw31");
        idle(1'b1);

        repeat (4) @(negedge clk);
        check("q3 drained", q3.size(), 32'd0);
        check("q1 drained", q1.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
